// File: rtl/rr_fsm_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_fsm_pkg
// Definitions shared by rr_fsm_arbiter, its interface and rr_pick:
//   - state_t and the 2-bit controller encoding (IDLE/GRANT/HOLD/RELEASE)
//   - default requester count, watchdog limit and watchdog counter width
//   - clog2w(): index width helper, never returns less than 1 bit
// ---------------------------------------------------------------------------
package rr_fsm_pkg;

   typedef logic [1:0] state_t;

   // Plain constants rather than an enum so the encoding can be compared
   // directly against older logic that decodes the raw 2-bit state.
   localparam state_t ST_IDLE    = 2'b00;
   localparam state_t ST_GRANT   = 2'b01;
   localparam state_t ST_HOLD    = 2'b10;
   localparam state_t ST_RELEASE = 2'b11;

   localparam int N_DEF        = 4;
   localparam int MAX_HOLD_DEF = 16;
   localparam int CW_DEF       = 5;

   // Width of an index into n items; a 1-bit field is kept even for n <= 2.
   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_fsm_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_fsm_arbiter_if
// Requester-side bus of the round-robin arbiter.
//   req     [N]   request vector, bit i belongs to requester i
//   done          current owner has finished (only looked at in HOLD)
//   gnt     [N]   one-hot grant
//   gnt_id  [IW]  index of the current/last owner
//   start         one-cycle pulse in the first grant cycle
//   busy          high while a grant is active (GRANT and HOLD)
//   timeout       one-cycle pulse when the hold watchdog forces a release
// Modports: master = arbiter side, slave = requester side.
// ---------------------------------------------------------------------------
interface rr_fsm_arbiter_if #(
   parameter int N = rr_fsm_pkg::N_DEF
);
   localparam int IW = rr_fsm_pkg::clog2w(N);

   logic [N-1:0]  req;
   logic          done;
   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_id;
   logic          start;
   logic          busy;
   logic          timeout;

   modport master (
      input  req, done,
      output gnt, gnt_id, start, busy, timeout
   );

   modport slave (
      output req, done,
      input  gnt, gnt_id, start, busy, timeout
   );

endinterface

// File: rtl/rr_fsm_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority encoder. Scans req starting at
// last_owner+1 and wrapping modulo N; the first set bit wins.
//   req         [N]   in   request vector
//   last_owner  [IW]  in   index of the previous owner (must be < N)
//   pick_onehot [N]   out  one-hot winner, zero when nothing is requested
//   pick_idx    [IW]  out  index of the winner
//   pick_valid        out  at least one request is set
// ---------------------------------------------------------------------------
module rr_pick
   import rr_fsm_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int IW = clog2w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_owner,
   output logic [N-1:0]  pick_onehot,
   output logic [IW-1:0] pick_idx,
   output logic          pick_valid
);

   // Candidate gi is the requester (gi+1) positions after the last owner.
   logic [IW-1:0] cand_idx [N];
   logic [N-1:0]  cand_req;

   for (genvar gi = 0; gi < N; gi++) begin : g_cand
      // One extra bit: last_owner + gi + 1 can reach 2N-1 before wrapping.
      logic [IW:0] sum;
      assign sum          = {1'b0, last_owner} + (IW+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N))
                                                : sum[IW-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
   end

   always_comb begin
      pick_onehot = '0;
      pick_idx    = '0;
      pick_valid  = 1'b0;
      // Walk from the farthest candidate down so the nearest one wins.
      for (int k = N - 1; k >= 0; k--) begin
         if (cand_req[k]) begin
            pick_idx   = cand_idx[k];
            pick_valid = 1'b1;
         end
      end
      if (pick_valid) begin
         pick_onehot[pick_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_fsm_arbiter.sv
// ---------------------------------------------------------------------------
// rr_fsm_arbiter
// Round-robin arbiter that hands a single-owner resource to one of N
// requesters at a time. A grant is held until the owner raises done or
// drops its request; then one RELEASE cycle and one IDLE cycle pass before
// the next grant, which goes to the next requester after the last owner.
//
// Ports:
//   clk    in   clock, everything on posedge
//   srst   in   synchronous reset, active high
//   bus    rr_fsm_arbiter_if.master (req, done in; gnt, gnt_id, start,
//          busy, timeout out - all outputs registered)
//
// Parameters: N (2..8 requesters), MAX_HOLD (watchdog limit in HOLD
// cycles), CW (watchdog width, 2^CW > MAX_HOLD).
//
// Build option RR_FSM_ARBITER_TIMEOUT_EN: adds a hold watchdog that forces
// a release after MAX_HOLD HOLD cycles and pulses timeout. Without it
// timeout is tied low and HOLD can last indefinitely.
// ---------------------------------------------------------------------------
module rr_fsm_arbiter
   import rr_fsm_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int CW       = CW_DEF
) (
   input logic              clk,
   input logic              srst,
   rr_fsm_arbiter_if.master bus
);

   localparam int IW = clog2w(N);

   // Elaboration-time parameter sanity checks.
   if (N < 2 || N > 8) begin : g_bad_n
      $error("rr_fsm_arbiter: N must be in 2..8");
   end
   if ((1 << CW) <= MAX_HOLD) begin : g_bad_cw
      $error("rr_fsm_arbiter: CW too narrow for MAX_HOLD");
   end

   state_t        state_q,      state_d;
   logic [N-1:0]  gnt_q,        gnt_d;
   logic [IW-1:0] gnt_id_q,     gnt_id_d;
   logic [IW-1:0] last_owner_q, last_owner_d;
   logic          start_q,      start_d;
   logic          busy_q,       busy_d;

   logic [N-1:0]  pick_onehot;
   logic [IW-1:0] pick_idx;
   logic          pick_valid;

   logic          owner_release;
   logic          wd_fire;
   logic          release_c;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req         (bus.req),
      .last_owner  (last_owner_q),
      .pick_onehot (pick_onehot),
      .pick_idx    (pick_idx),
      .pick_valid  (pick_valid)
   );

   // Owner-initiated release: done, or the owner abandoning its request.
   assign owner_release = bus.done | ~bus.req[gnt_id_q];
   assign release_c     = owner_release | wd_fire;

`ifdef RR_FSM_ARBITER_TIMEOUT_EN
   logic [CW-1:0] wd_q, wd_d;
   logic          timeout_q, timeout_d;

   // Fires in the MAX_HOLD-th HOLD cycle; counter is 0 during GRANT.
   assign wd_fire = (state_q == ST_HOLD) && (wd_q == CW'(MAX_HOLD - 1));

   always_comb begin
      wd_d      = wd_q;
      timeout_d = 1'b0;
      if (state_q == ST_IDLE && pick_valid) begin
         wd_d = '0;
      end else if (state_q == ST_HOLD) begin
         wd_d = wd_q + 1'b1;
      end
      // A simultaneous owner release wins; the pulse only flags a forced one.
      if (wd_fire && !owner_release) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign wd_fire     = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   // Outputs are registered, so each transition loads the output values
   // that belong to the state being entered.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      gnt_id_d     = gnt_id_q;
      last_owner_d = last_owner_q;
      start_d      = 1'b0;
      busy_d       = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d  = ST_GRANT;
               gnt_d    = pick_onehot;
               gnt_id_d = pick_idx;
               start_d  = 1'b1;
               busy_d   = 1'b1;
            end
         end
         ST_GRANT: begin
            // done is deliberately not looked at here.
            state_d = ST_HOLD;
            busy_d  = 1'b1;
         end
         ST_HOLD: begin
            // Other requesters never pre-empt; only the owner or watchdog.
            if (release_c) begin
               state_d = ST_RELEASE;
               gnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         ST_RELEASE: begin
            // gnt_id keeps the last owner for observers.
            state_d      = ST_IDLE;
            last_owner_d = gnt_id_q;
            gnt_d        = '0;
            busy_d       = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q      <= ST_IDLE;
         gnt_q        <= '0;
         gnt_id_q     <= '0;
         // Pointing at N-1 makes requester 0 the first candidate.
         last_owner_q <= IW'(N - 1);
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         gnt_id_q     <= gnt_id_d;
         last_owner_q <= last_owner_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.gnt_id = gnt_id_q;
   assign bus.start  = start_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_rr_fsm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_fsm_arbiter
// Self-checking bench for rr_fsm_arbiter. Expected grant indices are queued
// when requests are driven and popped when a start pulse appears.
// ---------------------------------------------------------------------------
module tb_rr_fsm_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 16;

   logic clk = 1'b0;
   logic srst;
   int   errors = 0;
   int   checks = 0;
   int   exp_q[$];

   rr_fsm_arbiter_if #(.N(N)) bus();

   rr_fsm_arbiter #(
      .N        (N),
      .MAX_HOLD (MAX_HOLD),
      .CW       (5)
   ) dut (
      .clk  (clk),
      .srst (srst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      srst     = 1'b1;
      bus.req  = '0;
      bus.done = 1'b0;
      step();
      step();
      srst = 1'b0;
   endtask

   // Steps until start is seen or the bound expires.
   task automatic wait_start(input int bound, output int steps, output bit seen);
      seen  = 1'b0;
      steps = 0;
      while (!seen && steps < bound) begin
         step();
         steps++;
         if (bus.start === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      srst     = 1'b1;
      bus.req  = 4'b1111;
      bus.done = 1'b0;
      step();
      checks++;
      if ({bus.gnt, bus.busy, bus.start, bus.timeout} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: got gnt=%b busy=%b start=%b timeout=%b required all 0",
                  bus.gnt, bus.busy, bus.start, bus.timeout);
      end
      checks++;
      if (bus.gnt_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_gnt_id: got %0d required 0", bus.gnt_id);
      end
      bus.req = '0;
      srst    = 1'b0;
      step();
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin
         errors++;
         $display("FAIL idle_no_req: got busy=%b gnt=%b required 0/0000", bus.busy, bus.gnt);
      end
      $display("reset: done");
   endtask

   task automatic test_single();
      int steps; bit seen; int e; logic [N-1:0] eg;
      do_reset();
      bus.req = 4'b0001;
      exp_q.push_back(0);
      wait_start(8, steps, seen);
      e  = exp_q.pop_front();
      eg = N'(1) << e;
      checks++;
      if (!seen || steps != 1) begin
         errors++;
         $display("FAIL single_latency: got seen=%0d steps=%0d required 1/1", seen, steps);
      end
      checks++;
      if (bus.gnt !== eg || bus.gnt_id !== 2'(e) || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: got gnt=%b id=%0d busy=%b required %b/%0d/1",
                  bus.gnt, bus.gnt_id, bus.busy, eg, e);
      end
      $display("single: grant id=%0d", bus.gnt_id);
      bus.done = 1'b1;                   // done during GRANT must be ignored
      step();
      bus.done = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.gnt !== 4'b0001 || bus.start !== 1'b0) begin
         errors++;
         $display("FAIL single_hold: got busy=%b gnt=%b start=%b required 1/0001/0",
                  bus.busy, bus.gnt, bus.start);
      end
      step();
      step();
      bus.done = 1'b1;                   // 3 cycles after start
      step();
      bus.done = 1'b0;
      checks++;
      if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.gnt_id !== 2'd0) begin
         errors++;
         $display("FAIL single_release: got gnt=%b busy=%b id=%0d required 0000/0/0",
                  bus.gnt, bus.busy, bus.gnt_id);
      end
      bus.req = '0;
      step();
   endtask

   task automatic test_rotation();
      int steps; bit seen; int e; logic [N-1:0] eg;
      do_reset();
      bus.req = 4'b1111;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      exp_q.push_back(3); exp_q.push_back(0);
      for (int g = 0; g < 5; g++) begin
         wait_start(8, steps, seen);
         e  = exp_q.pop_front();
         eg = N'(1) << e;
         checks++;
         if (!seen || steps != ((g == 0) ? 1 : 2)) begin
            errors++;
            $display("FAIL rotation_gap: grant %0d got seen=%0d steps=%0d required %0d",
                     g, seen, steps, (g == 0) ? 1 : 2);
         end
         checks++;
         if (bus.gnt_id !== 2'(e) || bus.gnt !== eg) begin
            errors++;
            $display("FAIL rotation_order: grant %0d got id=%0d gnt=%b required %0d/%b",
                     g, bus.gnt_id, bus.gnt, e, eg);
         end
         $display("rotation: grant %0d id=%0d", g, bus.gnt_id);
         step();
         bus.done = 1'b1;
         step();
         bus.done = 1'b0;
         checks++;
         if (bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin
            errors++;
            $display("FAIL rotation_release: got busy=%b gnt=%b required 0/0000", bus.busy, bus.gnt);
         end
      end
      bus.req = '0;
      step();
      step();
   endtask

   task automatic test_abandon();
      int steps; bit seen; int e;
      do_reset();
      bus.req = 4'b0100;
      exp_q.push_back(2);
      wait_start(8, steps, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || bus.gnt_id !== 2'(e) || bus.gnt !== 4'b0100) begin
         errors++;
         $display("FAIL abandon_grant: got id=%0d gnt=%b required %0d/0100", bus.gnt_id, bus.gnt, e);
      end
      $display("abandon: grant id=%0d", bus.gnt_id);
      step();
      bus.req = 4'b0010;                 // owner 2 drops, 1 keeps asking
      step();
      checks++;
      if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.gnt_id !== 2'd2) begin
         errors++;
         $display("FAIL abandon_release: got gnt=%b busy=%b id=%0d required 0000/0/2",
                  bus.gnt, bus.busy, bus.gnt_id);
      end
      exp_q.push_back(1);
      wait_start(8, steps, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || steps != 2 || bus.gnt_id !== 2'(e) || bus.gnt !== 4'b0010) begin
         errors++;
         $display("FAIL abandon_next: got seen=%0d steps=%0d id=%0d gnt=%b required 1/2/%0d/0010",
                  seen, steps, bus.gnt_id, bus.gnt, e);
      end
      $display("abandon: grant id=%0d", bus.gnt_id);
      step();
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      bus.req  = '0;
      step();
   endtask

   task automatic test_reset_mid_grant();
      int steps; bit seen; int e;
      do_reset();
      bus.req = 4'b0100;
      exp_q.push_back(2);
      wait_start(8, steps, seen);
      e = exp_q.pop_front();
      step();
      checks++;
      if (!seen || bus.gnt !== 4'b0100 || bus.gnt_id !== 2'(e)) begin
         errors++;
         $display("FAIL midreset_hold: got gnt=%b id=%0d required 0100/%0d", bus.gnt, bus.gnt_id, e);
      end
      srst    = 1'b1;
      bus.req = 4'b1111;
      step();
      checks++;
      if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.gnt_id !== 2'd0 || bus.start !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear: got gnt=%b busy=%b id=%0d start=%b required 0000/0/0/0",
                  bus.gnt, bus.busy, bus.gnt_id, bus.start);
      end
      srst = 1'b0;
      exp_q.push_back(0);
      wait_start(8, steps, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || steps != 1 || bus.gnt_id !== 2'(e) || bus.gnt !== 4'b0001) begin
         errors++;
         $display("FAIL midreset_first: got seen=%0d steps=%0d id=%0d gnt=%b required 1/1/%0d/0001",
                  seen, steps, bus.gnt_id, bus.gnt, e);
      end
      $display("midreset: grant id=%0d", bus.gnt_id);
      step();
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      bus.req  = '0;
      step();
   endtask

   task automatic test_done_and_drop();
      int steps; bit seen; int e; int starts; int pulses;
      do_reset();
      bus.req = 4'b0010;
      exp_q.push_back(1);
      wait_start(8, steps, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || bus.gnt_id !== 2'(e)) begin
         errors++;
         $display("FAIL both_grant: got seen=%0d id=%0d required 1/%0d", seen, bus.gnt_id, e);
      end
      $display("both: grant id=%0d", bus.gnt_id);
      step();
      bus.done = 1'b1;
      bus.req  = '0;
      step();
      bus.done = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.gnt !== 4'b0 || bus.timeout !== 1'b0) begin
         errors++;
         $display("FAIL both_release: got busy=%b gnt=%b timeout=%b required 0/0000/0",
                  bus.busy, bus.gnt, bus.timeout);
      end
      starts = 0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.start === 1'b1) starts++;
         if (bus.timeout === 1'b1) pulses++;
      end
      checks++;
      if (starts != 0 || pulses != 0) begin
         errors++;
         $display("FAIL both_single_release: got starts=%0d timeouts=%0d required 0/0", starts, pulses);
      end
   endtask

`ifdef RR_FSM_ARBITER_TIMEOUT_EN
   task automatic test_timeout();
      int steps; bit seen; int e; int n;
      do_reset();
      bus.req = 4'b0011;
      exp_q.push_back(0);
      wait_start(8, steps, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || bus.gnt_id !== 2'(e)) begin
         errors++;
         $display("FAIL timeout_grant: got seen=%0d id=%0d required 1/%0d", seen, bus.gnt_id, e);
      end
      n = 0;
      while (bus.timeout !== 1'b1 && n < MAX_HOLD + 8) begin
         step();
         n++;
      end
      checks++;
      if (bus.timeout !== 1'b1 || n != MAX_HOLD + 1 || bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_fire: got timeout=%b after=%0d gnt=%b busy=%b required 1/%0d/0000/0",
                  bus.timeout, n, bus.gnt, bus.busy, MAX_HOLD + 1);
      end
      $display("timeout: fired after %0d cycles", n);
      step();
      checks++;
      if (bus.timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: got %b required 0", bus.timeout);
      end
      exp_q.push_back(1);
      wait_start(8, steps, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || bus.gnt_id !== 2'(e) || bus.gnt !== 4'b0010) begin
         errors++;
         $display("FAIL timeout_next: got seen=%0d id=%0d gnt=%b required 1/%0d/0010",
                  seen, bus.gnt_id, bus.gnt, e);
      end
      $display("timeout: next grant id=%0d", bus.gnt_id);
      step();
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      bus.req  = '0;
      step();
   endtask
`else
   task automatic test_long_hold();
      int steps; bit seen; int e; int pulses;
      do_reset();
      bus.req = 4'b0001;
      exp_q.push_back(0);
      wait_start(8, steps, seen);
      e = exp_q.pop_front();
      pulses = 0;
      for (int i = 0; i < 3 * MAX_HOLD; i++) begin
         step();
         if (bus.timeout !== 1'b0) pulses++;
      end
      checks++;
      if (!seen || bus.busy !== 1'b1 || bus.gnt_id !== 2'(e) || pulses != 0) begin
         errors++;
         $display("FAIL long_hold: got seen=%0d busy=%b id=%0d timeouts=%0d required 1/1/%0d/0",
                  seen, bus.busy, bus.gnt_id, pulses, e);
      end
      $display("long_hold: held id=%0d for %0d cycles", bus.gnt_id, 3 * MAX_HOLD);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      bus.req  = '0;
      step();
   endtask
`endif

   initial begin
      srst     = 1'b1;
      bus.req  = '0;
      bus.done = 1'b0;
      test_reset();
      test_single();
      test_rotation();
      test_abandon();
      test_reset_mid_grant();
      test_done_and_drop();
`ifdef RR_FSM_ARBITER_TIMEOUT_EN
      test_timeout();
`else
      test_long_hold();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %0d entries left required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_fsm_arbiter.md
Name: rr_fsm_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one single-owner resource (e.g. a handshake FSM driven through a serial control bit) among N requesters.
- Grants one requester at a time and holds the grant until the owner signals done or drops its request.
- Sits between the requester blocks and the shared resource; its 4-phase controller mirrors the Idle/Start/Stop/Clear control style used elsewhere in the codebase.

Parameters:
- N, 4, number of requesters; legal range 2..8.
- MAX_HOLD, 16, watchdog limit on cycles in HOLD; used only with the optional feature.
- CW, 5, watchdog counter width; must satisfy 2^CW > MAX_HOLD.

Ports:
- Clock  in  1  single clock; all logic on posedge.
- Reset  in  1  synchronous reset, active-high.
- req  in  N  request vector; bit i is requester i.
- done  in  1  owner finished; sampled only in HOLD.
- gnt  out  N  one-hot grant, registered.
- gnt_id  out  clog2(N)  index of the current/last owner, registered.
- start  out  1  one-cycle pulse in the first grant cycle.
- busy  out  1  high in GRANT and HOLD.
- timeout  out  1  one-cycle pulse when the watchdog fires; tied 0 when the feature is compiled out.

Behaviour:
- Reset values (Reset=1 at posedge): state=IDLE, gnt=0, gnt_id=0, start=0, busy=0, timeout=0, last_owner=N-1, watchdog=0. This gives requester 0 top priority after reset.
- Reset asserted mid-grant: gnt drops at the next edge. No RELEASE cycle. last_owner reverts to N-1.
- States, 2-bit encoding: IDLE=00, GRANT=01, HOLD=10, RELEASE=11.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise pick the first set bit scanning last_owner+1, +2, … modulo N (wrap-around).
  - Register gnt/gnt_id and go to GRANT.
  - Latency: req high at edge k gives gnt high after edge k+1 (1 cycle).
- GRANT:
  - start=1, busy=1, gnt held. Unconditionally go to HOLD.
  - done in this cycle is ignored.
- HOLD:
  - busy=1, gnt held.
  - Exit to RELEASE when done=1, or when req[gnt_id]=0 (abandon).
  - Both events in the same cycle are treated as a single release.
  - Requests from other requesters never pre-empt the owner.
- RELEASE:
  - gnt=0, busy=0; last_owner<=gnt_id; go to IDLE.
  - gnt_id keeps its value.
  - Minimum gap between consecutive grants: 2 dead cycles (RELEASE, IDLE).
- Fairness: any continuously asserted request is granted within N-1 other grants.
- A request deasserted while in IDLE before selection is simply not chosen; no memory of past requests.
- gnt is always one-hot or zero. gnt!=0 exactly when busy=1, except that gnt stays high through the cycle a state transitions into RELEASE.
- Illegal state (unreachable) goes to IDLE with gnt=0.

Optional Feature:
- Macro: RR_FSM_ARBITER_TIMEOUT_EN.
- When defined:
  - Watchdog clears on entering GRANT and increments each HOLD cycle.
  - If the count reaches MAX_HOLD with no release, force RELEASE and pulse timeout for 1 cycle (same cycle as RELEASE).
  - done and the watchdog firing together count as a normal release; timeout=0.
- When undefined:
  - No counter logic; timeout tied 0; HOLD may last indefinitely.

Decomposition:
- Shared package rr_fsm_pkg holds:
  - The state typedef/encoding (IDLE, GRANT, HOLD, RELEASE).
  - Default N and MAX_HOLD constants.
  - A clog2 width helper.
- One natural sub-module: rr_pick, a combinational rotate-priority encoder (req, last_owner → one-hot pick, index, valid). It is reused by other arbiters in the codebase.

Test Plan:
- Reset then req=4'b0001 held, done pulse 3 cycles after start → gnt=0001 one cycle after req; start pulses once; gnt clears at RELEASE; gnt_id=0.
- req=4'b1111 constant, done after each start → grant order 0,1,2,3,0; 2 dead cycles between grants.
- Owner 2 in HOLD; req[2] drops while req[1] held → RELEASE next edge; the next grant goes to 1, wrapping via 3,0,1 (3 and 0 idle).
- Reset asserted during HOLD with gnt=0100 → next edge gnt=0, busy=0; after release, req=1111 grants requester 0 first.
- With RR_FSM_ARBITER_TIMEOUT_EN, MAX_HOLD=16, done never asserted → timeout pulses 16 HOLD cycles after GRANT; gnt clears; the next requester is served.
- done and req[owner] drop together in HOLD → a single RELEASE, no extra grant; timeout stays 0.
